bin_to_bcd_seq: RTL and testbench

//   Sequential shift-add-3 (double-dabble) converter: unsigned binary switch value -> packed BCD digits.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
//   Definitions shared by the display path: switch capture, the binary-to-BCD
//   converter and the 7-segment digit scanner.
//   - state_t      : converter FSM encoding (ST_IDLE, ST_CONVERT, ST_DONE)
//   - BCD_DIGIT_W  : bits per packed BCD digit
//   - BCD_BLANK    : digit code the scanner renders as an unlit digit
//   - BCD_MAX_DIGIT: largest legal decimal digit
// ----------------------------------------------------------------------------
package disp_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_BLANK     = 4'hF;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    // Encoding 2'd3 is unused; the converter steers it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage : disp_pkg

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
//   Double-dabble digit correction: a digit of 5 or more gets +3 so that the
//   following left shift carries correctly into the next decimal digit.
//   Ports:
//     digit_i  in   4   BCD scratch digit before the shift
//     digit_o  out  4   corrected digit (4-bit result, no carry out)
// ----------------------------------------------------------------------------
module bcd_add3
    import disp_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential shift-add-3 converter from an unsigned binary value to packed
//   BCD, one input bit per clock. The last result is held for the digit
//   scanner until the next conversion completes.
//   Parameters:
//     IN_WIDTH  width of the binary input
//     DIGITS    number of BCD output digits
//   Ports:
//     clk       in   1             clock, rising edge
//     reset     in   1             asynchronous reset, active low
//     bin_in    in   IN_WIDTH      value, sampled only when start is accepted
//     start     in   1             conversion request, accepted only in idle
//     busy      out  1             conversion in progress, start ignored
//     done      out  1             one-cycle pulse: bcd_out/overflow updated
//     bcd_out   out  4*DIGITS      packed BCD, ones digit in [3:0]
//     overflow  out  1             value did not fit in DIGITS digits
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import disp_pkg::*;
#(
    parameter int IN_WIDTH = 13,
    parameter int DIGITS   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           bin_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);

    state_t               state_q,   state_d;
    logic [IN_WIDTH-1:0]  shift_q,   shift_d;
    logic [SCR_W-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 sticky_q,  sticky_d;
    logic [SCR_W-1:0]     bcd_q,     bcd_d;
    logic                 ovf_q,     ovf_d;
    logic                 done_q,    done_d;

    logic [SCR_W-1:0]     adjusted;

    // Every digit is corrected independently before the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adjusted [gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    sticky_d  = 1'b0;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // {carry, scratch, shift} <<= 1 on the corrected digits; the
                // bit leaving the top digit marks an out-of-range value.
                scratch_d = {adjusted[SCR_W-2:0], shift_q[IN_WIDTH-1]};
                shift_d   = shift_q << 1;
                sticky_d  = sticky_q | adjusted[SCR_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ST_CONVERT) || (state_q == ST_DONE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
    import disp_pkg::*;

    localparam int LAT = 14;   // accept edge to done-visible edge

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] bin_a = '0, bin_b = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] bcd_a;
    logic [7:0]  bcd_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.IN_WIDTH(13), .DIGITS(4)) dut_a (
        .clk(clk), .reset(reset), .bin_in(bin_a), .start(start_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));

    bin_to_bcd_seq #(.IN_WIDTH(13), .DIGITS(2)) dut_b (
        .clk(clk), .reset(reset), .bin_in(bin_b), .start(start_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 4-digit converter.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_bcd", 32'(bcd_a), 32'(e.bcd));
                check("a_ovf", 32'(ovf_a), 32'(e.ovf));
                check("a_latency_cycle", 32'(cyc), 32'(e.cyc));
                $display("dut_a done: cycle=%0d bcd=%h ovf=%0b", cyc, bcd_a, ovf_a);
            end
        end
    end

    // Monitor for the 2-digit converter.
    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_bcd", 32'(bcd_b), 32'(e.bcd));
                check("b_ovf", 32'(ovf_b), 32'(e.ovf));
                check("b_latency_cycle", 32'(cyc), 32'(e.cyc));
                $display("dut_b done: cycle=%0d bcd=%h ovf=%0b", cyc, bcd_b, ovf_b);
            end
        end
    end

    // Called at a negedge: one-cycle start pulse; pushes the expectation keyed
    // to the accepting edge when push is set.
    task automatic issue(input bit to_b, input logic [12:0] val,
                         input logic [15:0] exp_bcd, input logic exp_ovf, input bit push);
        exp_t e;
        if (to_b) begin bin_b = val; start_b = 1'b1; end
        else      begin bin_a = val; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (push) begin
            e.bcd = exp_bcd; e.ovf = exp_ovf; e.cyc = cyc + LAT;
            if (to_b) q_b.push_back(e); else q_a.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            check(name, 32'(q_a.size() + q_b.size()), 32'd0);
            q_a.delete();
            q_b.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bcd",  32'(bcd_a),  32'd0);
        check("rst_ovf",  32'(ovf_a),  32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic conversions
        issue(0, 13'd0,    16'h0000, 1'b0, 1); drain("drain_zero");
        issue(0, 13'd8191, 16'h8191, 1'b0, 1); drain("drain_8191");
        issue(0, 13'd1234, 16'h1234, 1'b0, 1); drain("drain_1234");
        issue(0, 13'd9,    16'h0009, 1'b0, 1); drain("drain_9");

        // Start while busy is ignored; bin_in change has no effect
        issue(0, 13'd1234, 16'h1234, 1'b0, 1);
        repeat (4) @(negedge clk);
        check("busy_mid_conv", 32'(busy_a), 32'd1);
        issue(0, 13'd42, 16'h0000, 1'b0, 0);
        drain("drain_ignored");
        repeat (20) @(negedge clk);   // an extra done would be flagged by the monitor

        // Reset part-way through a conversion aborts it
        issue(0, 13'd4321, 16'h0000, 1'b0, 0);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_bcd",  32'(bcd_a),  32'd0);
        check("abort_ovf",  32'(ovf_a),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);   // no done may appear after release
        check("abort_idle_bcd", 32'(bcd_a), 32'd0);

        // Back-to-back: start held high, second value accepted the edge after
        // entering idle, so done pulses are IN_WIDTH+2 = 15 cycles apart.
        bin_a = 13'd700; start_a = 1'b1;
        @(negedge clk);
        n = cyc;
        e.bcd = 16'h0700; e.ovf = 1'b0; e.cyc = n + LAT; q_a.push_back(e);
        bin_a = 13'd5;
        while (cyc < n + 15) @(negedge clk);
        start_a = 1'b0;
        e.bcd = 16'h0005; e.ovf = 1'b0; e.cyc = n + 15 + LAT; q_a.push_back(e);
        drain("drain_b2b");

        // Two-digit instance: overflow boundary
        issue(1, 13'd150, 16'h0050, 1'b1, 1); drain("drain_150");
        issue(1, 13'd99,  16'h0099, 1'b0, 1); drain("drain_99");
        issue(1, 13'd100, 16'h0000, 1'b1, 1); drain("drain_100");
        check("b_ovf_held", 32'(ovf_b), 32'd1);
        check("a_bcd_held", 32'(bcd_a), 32'h0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bin_to_bcd_seq
